// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and constants for the register-file write-port
//            arbiter (request record, grant encoding, x0 register index).
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  // Default write-data width of the register file
  localparam int WB_DWIDTH = 32;

  // Architectural zero register; writes to it are consumed but never performed
  localparam logic [4:0] REG_X0 = 5'd0;

  // One register-file write request
  typedef struct packed {
    logic [4:0]           rd;
    logic [WB_DWIDTH-1:0] data;
  } wb_req_t;

  // Write-port grant
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LU   = 2'd2
  } wb_grant_t;

endpackage
`default_nettype wire

// File: rtl/wb_lu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_lu_fifo
// Purpose  : Synchronous FIFO holding long-latency-unit results (rd + data)
//            until they win the register-file write port. Exposes per-slot
//            valid bits and destinations so hazard logic can see them.
// Revision : 1.0 - initial release
// ============================================================================
module wb_lu_fifo
  import wb_arb_pkg::*;
#(
  parameter int DWIDTH = WB_DWIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [4:0]          push_rd,
  input  logic [DWIDTH-1:0]   push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [4:0]          head_rd,
  output logic [DWIDTH-1:0]   head_data,
  output logic [DEPTH-1:0]    entry_valid,
  output logic [DEPTH*5-1:0]  entry_rd
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [4:0]         r_rd_mem   [DEPTH];
  logic [DWIDTH-1:0]  r_data_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Guard against overflow/underflow even if the caller misbehaves
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head_rd   = r_rd_mem[r_rptr];
  assign head_data = r_data_mem[r_rptr];

  // Storage array: written on push, no reset needed since occupancy gates use
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= push_rd;
      r_data_mem[r_wptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [c_ptr_w-1:0] w_off;
    assign w_off             = c_ptr_w'(i) - r_rptr;
    assign entry_valid[i]    = ({1'b0, w_off} < r_count);
    assign entry_rd[i*5 +: 5] = r_rd_mem[i];
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Arbitrates the single register-file write port between the
//            in-order pipeline writeback and buffered long-latency-unit
//            results. Pipeline wins by default; an aging counter forces the
//            FIFO head through after MAX_WAIT lost arbitrations.
//            Optional macro WB_ARB_PERF_EN adds stall/force event counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [DWIDTH-1:0] pipe_data_i,
  output logic              pipe_ready_o,
  input  logic              lu_valid_i,
  input  logic [4:0]        lu_rd_i,
  input  logic [DWIDTH-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_rd_o,
  output logic [DWIDTH-1:0] rf_data_o,
  output logic [31:0]       pending_mask_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]       pipe_stall_cnt_o,
  output logic [31:0]       lu_force_cnt_o
`endif
);

  localparam int                 c_age_w   = $clog2(MAX_WAIT + 1);
  localparam logic [c_age_w-1:0] c_age_max = c_age_w'(MAX_WAIT);

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [4:0]         w_head_rd;
  logic [DWIDTH-1:0]  w_head_data;
  logic [DEPTH-1:0]   w_entry_valid;
  logic [DEPTH*5-1:0] w_entry_rd;
  logic               w_push;
  logic               w_pop;
  wb_grant_t          w_grant;
  logic [4:0]         w_sel_rd;
  logic [DWIDTH-1:0]  w_sel_data;
  logic [c_age_w-1:0] r_age;

  // Readiness depends on pre-pop state, so a full FIFO blocks enqueue even
  // in the cycle its head is popped
  assign lu_ready_o = !w_fifo_full;
  assign w_push     = lu_valid_i && !w_fifo_full;
  assign w_pop      = (w_grant == GNT_LU);

  wb_lu_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_lu_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (w_push),
    .push_rd     (lu_rd_i),
    .push_data   (lu_data_i),
    .pop         (w_pop),
    .full        (w_fifo_full),
    .empty       (w_fifo_empty),
    .head_rd     (w_head_rd),
    .head_data   (w_head_data),
    .entry_valid (w_entry_valid),
    .entry_rd    (w_entry_rd)
  );

  // Grant: pipeline by default, FIFO when alone or when its head has aged out
  always_comb begin
    w_grant = GNT_NONE;
    if (pipe_valid_i && !w_fifo_empty) begin
      w_grant = (r_age == c_age_max) ? GNT_LU : GNT_PIPE;
    end else if (pipe_valid_i) begin
      w_grant = GNT_PIPE;
    end else if (!w_fifo_empty) begin
      w_grant = GNT_LU;
    end
  end

  assign pipe_ready_o = !((w_grant == GNT_LU) && pipe_valid_i);

  // Source mux feeding the write-port register
  always_comb begin
    w_sel_rd   = pipe_rd_i;
    w_sel_data = pipe_data_i;
    if (w_grant == GNT_LU) begin
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
    end
  end

  // Registered write port; x0 targets are consumed without a write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= '0;
      rf_data_o <= '0;
    end else if (w_grant != GNT_NONE) begin
      rf_we_o   <= (w_sel_rd != REG_X0);
      rf_rd_o   <= w_sel_rd;
      rf_data_o <= w_sel_data;
    end else begin
      rf_we_o   <= 1'b0;
    end
  end

  // Aging: counts lost arbitrations of the FIFO head, saturating at MAX_WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_age <= '0;
    end else if (w_pop || w_fifo_empty) begin
      r_age <= '0;
    end else if ((w_grant == GNT_PIPE) && (r_age != c_age_max)) begin
      r_age <= r_age + c_age_w'(1);
    end
  end

  // Destinations still buffered, for hazard detection; x0 never reported
  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) pending_mask_o[w_entry_rd[i*5 +: 5]] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

`ifdef WB_ARB_PERF_EN
  // Event counters: pipeline stalls and forced FIFO grants (same event,
  // viewed from each side of the arbiter)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_stall_cnt_o <= '0;
      lu_force_cnt_o   <= '0;
    end else begin
      if (pipe_valid_i && !pipe_ready_o) pipe_stall_cnt_o <= pipe_stall_cnt_o + 32'd1;
      if (pipe_valid_i && (w_grant == GNT_LU)) lu_force_cnt_o <= lu_force_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: directed scenarios
//            followed by random traffic, checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DWIDTH   = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              reset;
  logic              pipe_valid_i;
  logic [4:0]        pipe_rd_i;
  logic [DWIDTH-1:0] pipe_data_i;
  logic              pipe_ready_o;
  logic              lu_valid_i;
  logic [4:0]        lu_rd_i;
  logic [DWIDTH-1:0] lu_data_i;
  logic              lu_ready_o;
  logic              rf_we_o;
  logic [4:0]        rf_rd_o;
  logic [DWIDTH-1:0] rf_data_o;
  logic [31:0]       pending_mask_o;
`ifdef WB_ARB_PERF_EN
  logic [31:0]       pipe_stall_cnt_o;
  logic [31:0]       lu_force_cnt_o;
`endif

  wb_port_arbiter #(
    .DWIDTH   (DWIDTH),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_valid_i   (pipe_valid_i),
    .pipe_rd_i      (pipe_rd_i),
    .pipe_data_i    (pipe_data_i),
    .pipe_ready_o   (pipe_ready_o),
    .lu_valid_i     (lu_valid_i),
    .lu_rd_i        (lu_rd_i),
    .lu_data_i      (lu_data_i),
    .lu_ready_o     (lu_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_rd_o        (rf_rd_o),
    .rf_data_o      (rf_data_o),
    .pending_mask_o (pending_mask_o)
`ifdef WB_ARB_PERF_EN
    ,
    .pipe_stall_cnt_o (pipe_stall_cnt_o),
    .lu_force_cnt_o   (lu_force_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of buffered LU results plus a wait counter
  typedef struct {
    logic [4:0]        rd;
    logic [DWIDTH-1:0] data;
  } ent_t;

  ent_t              q[$];
  int                age;
  logic              exp_we;
  logic [4:0]        exp_rd;
  logic [DWIDTH-1:0] exp_data;
  int                n_checks;
  int                n_pass;
  int                x0_mask_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    age      = 0;
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
  endtask

  // One clock of traffic, entered shortly after a rising edge
  task automatic cycle(input logic pv, input logic [4:0] prd, input logic [DWIDTH-1:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [DWIDTH-1:0] ld);
    bit          f, gl, gp, push;
    logic [31:0] m;
    pipe_valid_i = pv;
    pipe_rd_i    = prd;
    pipe_data_i  = pd;
    lu_valid_i   = lv;
    lu_rd_i      = lrd;
    lu_data_i    = ld;
    #2;
    f  = (q.size() > 0);
    gl = f && (!pv || age == MAX_WAIT);
    gp = pv && !gl;
    m  = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    m[0] = 1'b0;
    if (pending_mask_o[0] !== 1'b0) x0_mask_seen++;
    check("pipe_ready", 64'(pipe_ready_o), 64'(!(gl && pv)));
    check("lu_ready", 64'(lu_ready_o), 64'(q.size() < DEPTH));
    check("pending_mask", 64'(pending_mask_o), 64'(m));
    push = lv && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (gp) begin
      exp_we = (prd != 5'd0); exp_rd = prd; exp_data = pd;
    end else if (gl) begin
      exp_we = (q[0].rd != 5'd0); exp_rd = q[0].rd; exp_data = q[0].data;
      void'(q.pop_front());
    end else begin
      exp_we = 1'b0;
    end
    if (gl || !f) age = 0;
    else if (gp && age < MAX_WAIT) age++;
    if (push) q.push_back('{lrd, ld});
    check("rf_we", 64'(rf_we_o), 64'(exp_we));
    check("rf_rd", 64'(rf_rd_o), 64'(exp_rd));
    check("rf_data", 64'(rf_data_o), 64'(exp_data));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    x0_mask_seen = 0;
    reset        = 1'b1;
    pipe_valid_i = 1'b0;
    pipe_rd_i    = '0;
    pipe_data_i  = '0;
    lu_valid_i   = 1'b0;
    lu_rd_i      = '0;
    lu_data_i    = '0;
    model_reset();

    // Reset state
    #3;
    check("rst_rf_we", 64'(rf_we_o), 64'd0);
    check("rst_rf_rd", 64'(rf_rd_o), 64'd0);
    check("rst_rf_data", 64'(rf_data_o), 64'd0);
    check("rst_mask", 64'(pending_mask_o), 64'd0);
    check("rst_lu_ready", 64'(lu_ready_o), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pipeline write with empty FIFO
    cycle(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, '0);
    check("pipe_first_we", 64'(rf_we_o), 64'd1);
    check("pipe_first_rd", 64'(rf_rd_o), 64'd5);
    check("pipe_first_data", 64'(rf_data_o), 64'hA5);

    // LU result while pipeline idle: visible in mask, then written
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check("lu_write_rd", 64'(rf_rd_o), 64'd7);
    idle(2);

    // Aging: pipe held valid with one buffered entry
    cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h9999);
    for (int k = 0; k < 11; k++) cycle(1'b1, 5'(k + 2), 32'(k + 'h200), 1'b0, 5'd0, '0);
    idle(2);

    // Fill FIFO under a saturating pipeline; fifth result waits for a pop
    for (int k = 0; k < 4; k++) cycle(1'b1, 5'd3, 32'(k), 1'b1, 5'(k + 20), 32'(k + 'h40));
    for (int k = 0; k < 14; k++) cycle(1'b1, 5'd4, 32'(k), 1'b1, 5'd25, 32'h55);
    idle(8);

    // x0 targets from both sources are consumed without a write
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    idle(3);

    // Reset with three buffered entries
    for (int k = 0; k < 3; k++) cycle(1'b1, 5'd2, 32'(k), 1'b1, 5'(k + 11), 32'(k));
    pipe_valid_i = 1'b1;
    lu_valid_i   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_lu_ready", 64'(lu_ready_o), 64'd1);
    check("midrst_mask", 64'(pending_mask_o), 64'd0);
    check("midrst_rf_we", 64'(rf_we_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(9) < 7), 5'($urandom_range(31)), $urandom,
            ($urandom_range(1) == 1), 5'($urandom_range(31)), $urandom);
    end
    idle(10);

    check("mask_bit0_never", 64'(x0_mask_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
